// File: rtl/wrlvl_seq.sv
// DFI-side write-leveling sequencer: walks each rank, strobes the byte lanes until all
// enabled lanes respond, and reports pass/fail, erroring lanes and strobe timeouts.
module wrlvl_seq #(
    parameter int NUM_LANES  = 4,
    parameter int NUM_RANKS  = 2,
    parameter int STRB_GAP   = 16,
    parameter int SETTLE_CNT = 8,
    parameter int MAX_STRB   = 200
) (
    input  logic                 sclk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_LANES-1:0] lane_mask,
    input  logic [NUM_LANES-1:0] lane_resp,
    input  logic [NUM_LANES-1:0] lane_error,
    output logic                 wrlvl_en,
    output logic                 wrlvl_strobe,
    output logic                 wrlvl_cs_n,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [NUM_LANES-1:0] err_lanes,
    output logic                 timeout,
    output logic [9:0]           strb_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STRB, S_GAP, S_CHECK, S_RANK_END, S_ABORT, S_FIN
    } state_t;

    localparam int              CNT_MAX    = (SETTLE_CNT > STRB_GAP) ? SETTLE_CNT : STRB_GAP;
    localparam int              CW         = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]   SETTLE_LD  = CW'(SETTLE_CNT);
    localparam logic [CW-1:0]   GAP_LD     = CW'(STRB_GAP - 2);
    localparam logic [9:0]      MAX_STRB_C = 10'(MAX_STRB);
    localparam logic            LAST_RANK  = 1'(NUM_RANKS - 1);

    state_t               r_state,     w_state_nxt;
    logic [CW-1:0]        r_cnt,       w_cnt_nxt;
    logic [NUM_LANES-1:0] r_mask,      w_mask_nxt;
    logic                 r_rank,      w_rank_nxt;
    logic [9:0]           r_strb_cnt,  w_strb_cnt_nxt;
    logic                 r_fail,      w_fail_nxt;
    logic                 r_timeout,   w_timeout_nxt;
    logic [NUM_LANES-1:0] r_err_lanes, w_err_lanes_nxt;
    logic                 r_start_q,   r_start_qq;

    logic                 w_start_rise;
    logic                 w_cnt_last;
    logic [NUM_LANES-1:0] w_err_hit;
    logic                 w_all_resp;

    assign w_start_rise = r_start_q & ~r_start_qq;
    assign w_cnt_last   = (r_cnt == CW'(1));
    assign w_err_hit    = lane_error & r_mask;
    assign w_all_resp   = &(lane_resp | ~r_mask);

    // NOTE: every state register uses non-blocking assignment so all flops update
    // together from values computed in the previous cycle.
    always_ff @(posedge sclk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_rank      <= 1'b0;
            r_strb_cnt  <= '0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_lanes <= '0;
            r_start_q   <= 1'b0;
            r_start_qq  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mask      <= w_mask_nxt;
            r_rank      <= w_rank_nxt;
            r_strb_cnt  <= w_strb_cnt_nxt;
            r_fail      <= w_fail_nxt;
            r_timeout   <= w_timeout_nxt;
            r_err_lanes <= w_err_lanes_nxt;
            r_start_q   <= start;
            r_start_qq  <= r_start_q;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_mask_nxt      = r_mask;
        w_rank_nxt      = r_rank;
        w_strb_cnt_nxt  = r_strb_cnt;
        w_fail_nxt      = r_fail;
        w_timeout_nxt   = r_timeout;
        w_err_lanes_nxt = r_err_lanes;
        wrlvl_en        = 1'b0;
        wrlvl_strobe    = 1'b0;
        done            = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start_rise) begin
                    w_mask_nxt      = lane_mask;
                    w_fail_nxt      = 1'b0;
                    w_timeout_nxt   = 1'b0;
                    w_err_lanes_nxt = '0;
                    w_strb_cnt_nxt  = '0;
                    w_rank_nxt      = 1'b0;
                    w_cnt_nxt       = SETTLE_LD;
                    w_state_nxt     = (lane_mask == '0) ? S_FIN : S_SETUP;
                end
            end
            S_SETUP: begin
                wrlvl_en = 1'b1;
                if (w_cnt_last) w_state_nxt = S_STRB;
                else            w_cnt_nxt   = r_cnt - CW'(1);
            end
            S_STRB: begin
                wrlvl_en     = 1'b1;
                wrlvl_strobe = 1'b1;
                if (r_strb_cnt != 10'h3FF) w_strb_cnt_nxt = r_strb_cnt + 10'd1;
                w_cnt_nxt    = GAP_LD;
                w_state_nxt  = S_GAP;
            end
            S_GAP: begin
                wrlvl_en = 1'b1;
                if (w_cnt_last) w_state_nxt = S_CHECK;
                else            w_cnt_nxt   = r_cnt - CW'(1);
            end
            S_CHECK: begin
                // Lane status is sampled only here; error outranks response, response outranks timeout.
                wrlvl_en  = 1'b1;
                w_cnt_nxt = SETTLE_LD;
                if (w_err_hit != '0) begin
                    w_err_lanes_nxt = r_err_lanes | w_err_hit;
                    w_fail_nxt      = 1'b1;
                    w_state_nxt     = S_ABORT;
                end else if (w_all_resp) begin
                    w_state_nxt = S_RANK_END;
                end else if (r_strb_cnt == MAX_STRB_C) begin
                    w_timeout_nxt = 1'b1;
                    w_fail_nxt    = 1'b1;
                    w_state_nxt   = S_ABORT;
                end else begin
                    w_state_nxt = S_STRB;
                end
            end
            S_RANK_END: begin
                if (!w_cnt_last) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (r_rank != LAST_RANK) begin
                    w_rank_nxt     = r_rank + 1'b1;
                    w_strb_cnt_nxt = '0;
                    w_cnt_nxt      = SETTLE_LD;
                    w_state_nxt    = S_SETUP;
                end else begin
                    w_state_nxt = S_FIN;
                end
            end
            S_ABORT: begin
                if (w_cnt_last) w_state_nxt = S_FIN;
                else            w_cnt_nxt   = r_cnt - CW'(1);
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Chip select follows the rank register, which only moves while wrlvl_en is low.
    assign wrlvl_cs_n = ~r_rank;
    assign busy       = (r_state != S_IDLE);
    assign fail       = r_fail;
    assign timeout    = r_timeout;
    assign err_lanes  = r_err_lanes;
    assign strb_cnt   = r_strb_cnt;

endmodule

// File: tb/tb_wrlvl_seq.sv
// Bench for wrlvl_seq: directed scenario table, hand-written start/reset corner cases,
// and randomized scenarios whose expectations come from an arithmetic outcome model.
module tb_wrlvl_seq;

    localparam int NL = 4;
    localparam int NR = 2;
    localparam int S  = 8;
    localparam int G  = 16;
    localparam int MX = 20;

    logic          sclk = 1'b0;
    logic          reset;
    logic          start;
    logic [NL-1:0] lane_mask;
    logic [NL-1:0] lane_resp;
    logic [NL-1:0] lane_error;
    logic          wrlvl_en;
    logic          wrlvl_strobe;
    logic          wrlvl_cs_n;
    logic          busy;
    logic          done;
    logic          fail;
    logic [NL-1:0] err_lanes;
    logic          timeout;
    logic [9:0]    strb_cnt;

    always #5 sclk = ~sclk;

    wrlvl_seq #(
        .NUM_LANES (NL),
        .NUM_RANKS (NR),
        .STRB_GAP  (G),
        .SETTLE_CNT(S),
        .MAX_STRB  (MX)
    ) dut (
        .sclk        (sclk),
        .reset       (reset),
        .start       (start),
        .lane_mask   (lane_mask),
        .lane_resp   (lane_resp),
        .lane_error  (lane_error),
        .wrlvl_en    (wrlvl_en),
        .wrlvl_strobe(wrlvl_strobe),
        .wrlvl_cs_n  (wrlvl_cs_n),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .err_lanes   (err_lanes),
        .timeout     (timeout),
        .strb_cnt    (strb_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // thr[r][i]: lane i responds on rank r once that many strobes were seen (0 = never).
    typedef struct packed {
        logic [3:0]            mask;
        logic [1:0][3:0][4:0]  thr;
        logic                  err_en;
        logic                  err_rank;
        logic [4:0]            err_k;
        logic [3:0]            err_bits;
        logic [1:0]            exp_ranks;
        logic [1:0][9:0]       exp_k;
        logic                  exp_fail;
        logic                  exp_timeout;
        logic [3:0]            exp_err;
        logic [9:0]            exp_strb;
    } scen_t;

    scen_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic scen_t mk(input logic [3:0] mask, input logic [19:0] t0, input logic [19:0] t1,
                                 input logic err_en, input logic err_rank, input logic [4:0] err_k,
                                 input logic [3:0] err_bits, input logic [1:0] ranks,
                                 input logic [9:0] k0, input logic [9:0] k1, input logic f,
                                 input logic to, input logic [3:0] el, input logic [9:0] sc);
        scen_t s;
        s.mask        = mask;
        s.thr[0]      = t0;
        s.thr[1]      = t1;
        s.err_en      = err_en;
        s.err_rank    = err_rank;
        s.err_k       = err_k;
        s.err_bits    = err_bits;
        s.exp_ranks   = ranks;
        s.exp_k[0]    = k0;
        s.exp_k[1]    = k1;
        s.exp_fail    = f;
        s.exp_timeout = to;
        s.exp_err     = el;
        s.exp_strb    = sc;
        return s;
    endfunction

    // Outcome per rank: strobes needed = first of (error strobe, last lane response, MAX),
    // with error taking precedence over response, and response over timeout.
    function automatic scen_t model(input scen_t s_in);
        scen_t s;
        int    need, kr, ke, k;
        bit    never;
        s             = s_in;
        s.exp_ranks   = '0;
        s.exp_k       = '0;
        s.exp_fail    = 1'b0;
        s.exp_timeout = 1'b0;
        s.exp_err     = '0;
        s.exp_strb    = '0;
        if (s.mask != 4'd0) begin
            for (int r = 0; r < NR; r++) begin
                s.exp_ranks = 2'(r + 1);
                need  = 0;
                never = 1'b0;
                for (int i = 0; i < NL; i++) begin
                    if (s.mask[i]) begin
                        if (s.thr[r][i] == 5'd0) never = 1'b1;
                        else if (int'(s.thr[r][i]) > need) need = int'(s.thr[r][i]);
                    end
                end
                kr = never ? 100000 : need;
                ke = (s.err_en && int'(s.err_rank) == r && (s.err_bits & s.mask) != 4'd0)
                     ? int'(s.err_k) : 100000;
                k = MX;
                if (kr < k) k = kr;
                if (ke <= k) k = ke;
                s.exp_k[r]  = 10'(k);
                s.exp_strb  = 10'(k);
                if (k == ke) begin
                    s.exp_fail = 1'b1;
                    s.exp_err  = s.err_bits & s.mask;
                    break;
                end else if (k != kr) begin
                    s.exp_fail    = 1'b1;
                    s.exp_timeout = 1'b1;
                    break;
                end
            end
        end
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},      wrlvl_en, 0);
        check({tag, "_strobe"},  wrlvl_strobe, 0);
        check({tag, "_cs_n"},    wrlvl_cs_n, 1);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_done"},    done, 0);
        check({tag, "_fail"},    fail, 0);
        check({tag, "_err"},     err_lanes, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_strb"},    strb_cnt, 0);
    endtask

    // tog: pulse start low/high mid-run; rst_mid: assert reset in the rank-1 GAP after strobe 2.
    task automatic run_scen(input scen_t sc, input bit tog, input bit rst_mid);
        int   en_rises = 0;
        int   rank = 0;
        int   rank_strb = 0;
        int   exp_j, done_j, off1;
        int   kobs [2];
        logic prev_en, prev_cs;
        logic err_set = 1'b0;
        logic got_done = 1'b0;
        kobs[0] = 0;
        kobs[1] = 0;
        off1   = 2 * S + int'(sc.exp_k[0]) * G;
        done_j = 1 + ((sc.exp_ranks >= 2'd1) ? off1 : 0)
                   + ((sc.exp_ranks == 2'd2) ? 2 * S + int'(sc.exp_k[1]) * G : 0);
        @(negedge sclk);
        lane_resp  = '0;
        lane_error = '0;
        lane_mask  = sc.mask;
        start      = 1'b1;
        prev_en    = wrlvl_en;
        prev_cs    = wrlvl_cs_n;
        for (int j = 0; j < 3000; j++) begin
            @(negedge sclk);
            if (wrlvl_en && !prev_en) begin
                en_rises++;
                rank      = (en_rises > 1) ? 1 : 0;
                rank_strb = 0;
            end
            if (wrlvl_cs_n !== prev_cs) check("cs_n_moves_with_en_low", prev_en, 0);
            if (wrlvl_strobe) begin
                rank_strb++;
                kobs[rank]++;
                exp_j = 1 + ((rank == 1) ? off1 : 0) + S + (rank_strb - 1) * G;
                check("strobe_time", j, exp_j);
                check("strobe_cs_n", wrlvl_cs_n, (rank == 0));
            end
            if (done) begin
                got_done = 1'b1;
                check("done_time",  j, done_j);
                check("busy_done",  busy, 1);
                check("fail",       fail, sc.exp_fail);
                check("timeout",    timeout, sc.exp_timeout);
                check("err_lanes",  err_lanes, sc.exp_err);
                check("strb_cnt",   strb_cnt, sc.exp_strb);
                check("ranks_run",  en_rises, sc.exp_ranks);
                check("strobes_r0", kobs[0], sc.exp_k[0]);
                check("strobes_r1", kobs[1], sc.exp_k[1]);
                check("cs_n_final", wrlvl_cs_n, (sc.exp_ranks != 2'd2));
                break;
            end
            if (rst_mid && rank == 1 && rank_strb == 2 && !wrlvl_strobe) begin
                reset = 1'b1;
                start = 1'b0;
                @(negedge sclk);
                check_reset_outputs("midreset");
                repeat (2) begin
                    @(negedge sclk);
                    check("midreset_no_done", done, 0);
                end
                reset      = 1'b0;
                lane_resp  = '0;
                lane_error = '0;
                repeat (4) begin
                    @(negedge sclk);
                    check("after_reset_no_done", done, 0);
                    check("after_reset_idle", busy, 0);
                end
                return;
            end
            for (int i = 0; i < NL; i++)
                lane_resp[i] = (en_rises > 0) && (sc.thr[rank][i] != 5'd0)
                               && (rank_strb >= int'(sc.thr[rank][i]));
            if (sc.err_en && en_rises > 0 && rank == int'(sc.err_rank) && rank_strb >= int'(sc.err_k))
                err_set = 1'b1;
            lane_error = err_set ? sc.err_bits : 4'b0;
            if (tog && j == S + 5) start = 1'b0;
            if (tog && j == S + 7) start = 1'b1;
            prev_en = wrlvl_en;
            prev_cs = wrlvl_cs_n;
        end
        check("done_seen", got_done, 1);
        start = 1'b0;
        repeat (3) begin
            @(negedge sclk);
            check("done_one_cycle", done, 0);
            check("idle_busy", busy, 0);
            check("fail_held", fail, sc.exp_fail);
        end
        lane_resp  = '0;
        lane_error = '0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         mask     thr rank0                       thr rank1                       err: en rk k  bits     rk k0  k1 f  to err      strb
        tbl[0] = mk(4'hF,    {4{5'd5}},                      {4{5'd5}},                      0, 0, 0, 4'b0000, 2, 5,  5, 0, 0, 4'b0000, 5);
        tbl[1] = mk(4'b0101, {5'd0, 5'd3, 5'd0, 5'd3},       {5'd0, 5'd3, 5'd0, 5'd3},       0, 0, 0, 4'b0000, 2, 3,  3, 0, 0, 4'b0000, 3);
        tbl[2] = mk(4'hF,    20'd0,                          20'd0,                          1, 0, 7, 4'b0100, 1, 7,  0, 1, 0, 4'b0100, 7);
        tbl[3] = mk(4'hF,    20'd0,                          20'd0,                          0, 0, 0, 4'b0000, 1, 20, 0, 1, 1, 4'b0000, 20);
        tbl[4] = mk(4'hF,    {4{5'd4}},                      {4{5'd4}},                      1, 0, 4, 4'b0001, 1, 4,  0, 1, 0, 4'b0001, 4);
        tbl[5] = mk(4'h0,    {4{5'd2}},                      {4{5'd2}},                      0, 0, 0, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 0);
        tbl[6] = mk(4'b0011, {5'd0, 5'd0, 5'd2, 5'd6},       {5'd0, 5'd0, 5'd1, 5'd1},       1, 0, 2, 4'b1100, 2, 6,  1, 0, 0, 4'b0000, 1);

        reset      = 1'b1;
        start      = 1'b0;
        lane_mask  = '0;
        lane_resp  = '0;
        lane_error = '0;
        repeat (3) @(negedge sclk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge sclk);
        check("idle_after_reset", busy, 0);

        for (int n = 0; n < 7; n++) run_scen(tbl[n], 1'b0, 1'b0);

        run_scen(tbl[0], 1'b1, 1'b0);
        run_scen(tbl[0], 1'b0, 1'b1);
        run_scen(tbl[5], 1'b0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            scen_t s;
            s = '0;
            s.mask = 4'($urandom_range(0, 15));
            for (int r = 0; r < NR; r++)
                for (int i = 0; i < NL; i++)
                    s.thr[r][i] = 5'($urandom_range(0, 24));
            s.err_en   = ($urandom_range(0, 2) == 0);
            s.err_rank = 1'($urandom_range(0, 1));
            s.err_k    = 5'($urandom_range(1, 22));
            s.err_bits = 4'($urandom_range(1, 15));
            s = model(s);
            run_scen(s, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
